// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared state encoding and constants for the signed divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_ITER = ITER,
    S_FIX  = FIX,
    S_DONE = DONE
  } divState_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One restoring shift/subtract iteration (combinational).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] rem,
  input  logic           quo_msb,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] next_rem,
  output logic           q_bit
);

  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;

  // The partial remainder stays below the divisor, so its top bit is always
  // zero; carrying it into one extra bit keeps every input bit meaningful
  // while the borrow still lands in the sign bit of the difference.
  assign w_trial  = {rem, quo_msb};
  assign w_diff   = w_trial - {1'b0, divisor};
  assign q_bit    = ~w_diff[WIDTH+1];
  assign next_rem = q_bit ? w_diff[WIDTH:0] : w_trial[WIDTH:0];

endmodule

`default_nettype wire

// File: rtl/div_controller.sv
// ============================================================================
// Module : div_controller
// Brief  : Multi-cycle signed restoring divider with exception reporting.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_controller
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int             CW          = $clog2(WIDTH);
  localparam logic [CW-1:0]  c_lastIter  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_intMin  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_minusOne = '1;

  divState_t        r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   r_divisor;
  logic [WIDTH-1:0] r_quo;
  logic             r_neg;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_nextRem;
  logic             w_qBit;

  // Unsigned view of the negation makes |INT_MIN| come out exact.
  assign w_absA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_absB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .quo_msb  (r_quo[WIDTH-1]),
    .divisor  (r_divisor),
    .next_rem (w_nextRem),
    .q_bit    (w_qBit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rem          <= '0;
      r_divisor      <= '0;
      r_quo          <= '0;
      r_neg          <= 1'b0;
      r_count        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_DIV) begin
            busy <= 1'b1;
            if (data_operandB == '0) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              r_state        <= S_DONE;
            end else if (data_operandA == c_intMin && data_operandB == c_minusOne) begin
              data_result    <= c_intMin;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_divisor <= {1'b0, w_absB};
              r_quo     <= w_absA;
              r_rem     <= '0;
              r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              r_count   <= '0;
              r_state   <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_rem   <= w_nextRem;
          r_quo   <= {r_quo[WIDTH-2:0], w_qBit};
          r_count <= r_count + 1'b1;
          if (r_count == c_lastIter) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          data_result    <= r_neg ? -r_quo : r_quo;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
